// File: rtl/arbitro_rr_4a1_pkg.sv
// Shared definitions for the 4-to-1 round-robin merge arbiter.
package arbitro_rr_4a1_pkg;

  localparam int NUM_CLASS = 4;
  localparam int CLS_W     = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // Class index reached by stepping 'step' positions after 'base', wrapping mod 4.
  function automatic logic [CLS_W-1:0] cls_step(input logic [CLS_W-1:0] base,
                                                  input logic [CLS_W-1:0] step);
    return base + step;
  endfunction

endpackage

// File: rtl/arbitro_rr_4a1_rr_next.sv
// Round-robin search: first non-empty class after ptr, in the order ptr+1 .. ptr.
module rr_next_4
  import arbitro_rr_4a1_pkg::*;
(
  input  logic [CLS_W-1:0]     ptr,
  input  logic [NUM_CLASS-1:0] mask,
  output logic [CLS_W-1:0]     next,
  output logic                 found
);

  logic [NUM_CLASS-1:0] rot_s;
  logic [CLS_W-1:0]     off_s;

  // Rotate the mask so bit 0 is the class right after ptr (highest priority).
  always_comb begin
    rot_s = 4'b0000;
    for (int j = 0; j < NUM_CLASS; j++) begin
      rot_s[j] = mask[cls_step(ptr, 2'(j + 1))];
    end
  end

  // Priority pick on the rotated mask, then map the offset back to a class.
  always_comb begin
    off_s = 2'd0;
    found = 1'b1;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: begin
        off_s = 2'd3;
        found = 1'b0;
      end
    endcase
    next = cls_step(ptr, off_s + 2'd1);
  end

endmodule

// File: rtl/arbitro_rr_4a1.sv
// Four-to-one round-robin merge arbiter: burst-limited pops from four class
// FIFOs, two-stage pipeline into one output FIFO, Almost_full back-pressure.
module arbitro_rr_4a1
  import arbitro_rr_4a1_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int BURST  = 4
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          Enable,
  input  logic [NUM_CLASS-1:0]          FIFO_empty,
  input  logic [NUM_CLASS*DATA_W-1:0]   data_in,
  input  logic                          Almost_full,
  output logic [NUM_CLASS-1:0]          Pop,
  output logic                          Push,
  output logic [DATA_W-1:0]             data_out,
  output logic [CLS_W-1:0]              grant_id
);

  localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

  state_t             state_r, state_n;
  logic [CLS_W-1:0]   ptr_r, ptr_n;
  logic [CLS_W-1:0]   grant_r, grant_n;
  logic [3:0]         cnt_r, cnt_n;
  logic               v1_r;
  logic [CLS_W-1:0]   sel1_r;
  logic               push_r;
  logic [DATA_W-1:0]  dout_r;
  logic [CLS_W-1:0]   rr_next_s;
  logic               rr_found_s;
  logic               pop_ok_s;

  rr_next_4 u_rr_next (
    .ptr   (ptr_r),
    .mask  (~FIFO_empty),
    .next  (rr_next_s),
    .found (rr_found_s)
  );

  assign pop_ok_s = (state_r == ST_SERVE) & Enable & ~Almost_full & ~FIFO_empty[grant_r];

  // One-hot read strobe to the granted class; zero whenever a pop is not allowed.
  always_comb begin
    Pop = 4'b0000;
    if (pop_ok_s) begin
      Pop[grant_r] = 1'b1;
    end else begin
      Pop = 4'b0000;
    end
  end

  // Next-state logic: grant selection in IDLE, burst counting and release in SERVE.
  always_comb begin
    state_n = state_r;
    ptr_n   = ptr_r;
    grant_n = grant_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (Enable && rr_found_s) begin
          grant_n = rr_next_s;
          cnt_n   = 4'd0;
          state_n = ST_SERVE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (pop_ok_s) begin
          cnt_n = cnt_r + 4'd1;
          if (cnt_r == BURST_LAST) begin
            state_n = ST_IDLE;
            ptr_n   = grant_r;
          end else begin
            state_n = ST_SERVE;
          end
        end else if (Enable && !Almost_full && FIFO_empty[grant_r]) begin
          // Granted class ran dry: release without losing any word.
          state_n = ST_IDLE;
          ptr_n   = grant_r;
        end else begin
          state_n = ST_SERVE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      ptr_r   <= 2'd3;
      grant_r <= 2'd0;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      grant_r <= grant_n;
      cnt_r   <= cnt_n;
    end
  end

  // Read pipeline: stage 1 remembers the popped class, stage 2 captures its word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_r   <= 1'b0;
      sel1_r <= 2'd0;
      push_r <= 1'b0;
      dout_r <= '0;
    end else begin
      v1_r   <= pop_ok_s;
      sel1_r <= grant_r;
      push_r <= v1_r;
      if (v1_r) begin
        dout_r <= data_in[sel1_r*DATA_W +: DATA_W];
      end
    end
  end

  assign Push     = push_r;
  assign data_out = dout_r;
  assign grant_id = grant_r;

endmodule
